// File: rtl/io_port_controller_if.sv
// Board I/O bundle for io_port_controller: raw board inputs, datapath ports and display drive.
// master = board/datapath side, slave = the controller.
interface io_port_controller_if;
    logic [7:0]  raw_switches;
    logic        raw_load_btn;
    logic [31:0] outport_Data;
    logic [31:0] input_Data;
    logic        input_valid;
    logic [7:0]  anode;
    logic [6:0]  seg;

    modport master (
        output raw_switches,
        output raw_load_btn,
        output outport_Data,
        input  input_Data,
        input  input_valid,
        input  anode,
        input  seg
    );

    modport slave (
        input  raw_switches,
        input  raw_load_btn,
        input  outport_Data,
        output input_Data,
        output input_valid,
        output anode,
        output seg
    );
endinterface

// File: rtl/io_port_controller.sv
// Board I/O stage: synchronised/debounced switch load into the datapath inport, and an
// 8-digit multiplexed hex display of the outport. Optional macro IO_BLANK_LEADING_ZERO_EN blanks leading zeros.
module io_port_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 4
) (
    input logic                 clk,
    input logic                 clr,
    io_port_controller_if.slave io
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [7:0]       sw_meta;
    logic [7:0]       sw_sync;
    logic             btn_meta;
    logic             btn_sync;

    logic             btn_state;
    logic [CNT_W-1:0] cnt;
    logic             btn_differs;
    logic             cnt_tc;
    logic             commit_rise;

    logic [DIV_W-1:0] div;
    logic             div_tc;
    logic [2:0]       idx;
    logic [31:0]      snapshot;
    logic [3:0]       nibble;
    logic             blank;

    logic [31:0]      input_data_q;
    logic             input_valid_q;

    // Two-flop synchronisers; nothing downstream looks at the raw pins.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sw_meta  <= 8'd0;
            sw_sync  <= 8'd0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sw_meta  <= io.raw_switches;
            sw_sync  <= sw_meta;
            btn_meta <= io.raw_load_btn;
            btn_sync <= btn_meta;
        end
    end

    assign btn_differs = (btn_sync != btn_state);
    assign cnt_tc      = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign commit_rise = btn_differs && cnt_tc && btn_sync;

    // Any cycle where the synchronised button agrees with the committed state restarts the count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            btn_state <= 1'b0;
            cnt       <= '0;
        end else if (!btn_differs) begin
            cnt <= '0;
        end else if (cnt_tc) begin
            btn_state <= btn_sync;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            input_data_q  <= 32'd0;
            input_valid_q <= 1'b0;
        end else begin
            input_valid_q <= commit_rise;
            if (commit_rise) begin
                input_data_q <= {24'd0, sw_sync};
            end
        end
    end

    assign div_tc = (div == DIV_W'(SCAN_DIV - 1));

    // The snapshot only moves on the 7->0 wrap so a scan never mixes old and new digits.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div      <= '0;
            idx      <= 3'd0;
            snapshot <= 32'd0;
        end else if (div_tc) begin
            div <= '0;
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
                snapshot <= io.outport_Data;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        nibble = snapshot[{idx, 2'b00} +: 4];
`ifdef IO_BLANK_LEADING_ZERO_EN
        blank = (idx != 3'd0) && ((snapshot >> {idx, 2'b00}) == 32'd0);
`else
        blank = 1'b0;
`endif
    end

    always_comb begin
        io.seg = 7'h7F;
        if (!blank) begin
            case (nibble)
                4'h0: io.seg = 7'h40;
                4'h1: io.seg = 7'h79;
                4'h2: io.seg = 7'h24;
                4'h3: io.seg = 7'h30;
                4'h4: io.seg = 7'h19;
                4'h5: io.seg = 7'h12;
                4'h6: io.seg = 7'h02;
                4'h7: io.seg = 7'h78;
                4'h8: io.seg = 7'h00;
                4'h9: io.seg = 7'h10;
                4'hA: io.seg = 7'h08;
                4'hB: io.seg = 7'h03;
                4'hC: io.seg = 7'h46;
                4'hD: io.seg = 7'h21;
                4'hE: io.seg = 7'h06;
                default: io.seg = 7'h0E;
            endcase
        end
    end

    assign io.anode       = ~(8'd1 << idx);
    assign io.input_Data  = input_data_q;
    assign io.input_valid = input_valid_q;

endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
- Board-facing I/O stage for the CPU datapath.
- Input side: synchronises and debounces raw switches and a load button, then presents a stable 32-bit word on input_Data, which feeds the datapath inport.
- Output side: consumes outport_Data from the datapath outport and drives an 8-digit multiplexed seven-segment display in hex.
- Snapshots the displayed value once per full scan, so the display never shows a mix of old and new digits.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required before the button state commits; legal range 2 to 2^20.
- SCAN_DIV, 4: clock cycles each digit stays lit before the scan advances; minimum 1.

Ports:
- clk  input  1  system clock
- clr  input  1  asynchronous active-high reset
- raw_switches  input  8  asynchronous switch levels
- raw_load_btn  input  1  asynchronous, bouncy load button, active-high
- outport_Data  input  32  value to display, from the datapath outport
- input_Data  output  32  debounced input word, to the datapath inport
- input_valid  output  1  one-cycle pulse when input_Data is updated
- anode  output  8  digit enables, active-low, one-hot-zero; bit 0 is the rightmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (async, clr=1):
  - input_Data=0, input_valid=0.
  - Internal state cleared: sync flops, debounced button state, debounce counter, scan divider, digit index and display snapshot all 0.
  - Therefore anode=8'hFE and seg=7'h40 (digit 0 shows "0") while in reset and on the first cycle after it.
  - Reset mid-debounce discards any partial count; reset mid-scan restarts the scan at digit 0.
- Synchronisers: raw_switches and raw_load_btn each pass through two flops. Only synchronised values are used downstream.
- Debounce (button only):
  - State btn_state; counter cnt.
  - When sync_btn == btn_state: cnt <= 0.
  - When they differ and cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - When they differ and cnt == DEBOUNCE_CYCLES-1: btn_state <= sync_btn and cnt <= 0.
  - Any bounce back before commit clears cnt.
- Load:
  - On the edge where btn_state commits 0→1: input_Data <= {24'b0, sync_switches} and input_valid is 1 for exactly that following cycle.
  - A 1→0 commit produces no pulse and leaves input_Data unchanged.
  - Latency: input_valid asserts DEBOUNCE_CYCLES+2 edges after the first edge that samples raw_load_btn high, provided the input is held stable.
  - Switch changes while the button is held have no effect until the next press.
- Scan:
  - The divider counts 0..SCAN_DIV-1.
  - On terminal count, the digit index increments modulo 8 and the divider wraps to 0.
  - On the edge where the index wraps 7→0, snapshot <= outport_Data. That value is shown for the whole next scan.
  - Full scan period is 8*SCAN_DIV cycles.
- Display decode:
  - anode = ~(1<<index).
  - seg is decoded combinationally from the registered index and snapshot nibble snapshot[4*index+3 : 4*index].
  - Hex encoding, active-low: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Simultaneous events: a load commit and a scan wrap on the same edge are independent and both take effect. outport_Data may change on any cycle; only the wrap-edge value is displayed.

Optional Feature:
- Macro: IO_BLANK_LEADING_ZERO_EN.
- Defined:
  - While digit index k>0 is lit, if all snapshot nibbles k..7 are zero, then seg=7'h7F (blank) and that digit's anode still asserts.
  - Digit 0 always shows its nibble, so snapshot 0 displays a single "0".
- Undefined: all 8 digits always show their hex value, including leading zeros.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and SCAN_DIV=2.
1. Reset → assert clr, then release → anode=FE, seg=40, input_Data=0, input_valid=0; clr pulsed mid-scan returns anode to FE asynchronously.
2. raw_switches=8'hA5; raw_load_btn held high cleanly → input_valid=1 exactly 6 edges after first high sample, for one cycle; input_Data=32'h000000A5. Releasing the button gives no pulse.
3. Button bounces 1,1,0,1,1,1,1... (pattern repeated at one value per cycle) → no pulse until 4 consecutive stable synchronised highs; exactly one pulse per press; held button gives no repeat.
4. outport_Data=32'h1234ABCD at the 7→0 wrap edge → digits 0..7 show D,C,B,A,4,3,2,1 (seg 21,46,03,08,19,30,24,79), each lit for 2 cycles. A change to outport_Data mid-scan is not displayed until the next wrap.
5. IO_BLANK_LEADING_ZERO_EN defined, snapshot=32'h000000F0 → digit0 seg=40, digit1 seg=0E, digits 2..7 seg=7F. Undefined → digits 2..7 seg=40.
6. Load commit coincides with the scan wrap edge → input_valid pulses and the snapshot loads on the same edge, with no interference between them.
